keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner; the producer of the keycode/key_ready pair used by the display shift logic.

---
 rtl/keypad_scan_if.sv | 19 +
 rtl/keypad_scan.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad pin/output bundle: the row/column matrix pins and the keycode/key_ready pair.
// Latency: none (wires only).
// Backpressure: none; key_ready is a level, consumed downstream on its falling edge.
//
// Signals:
//   col_n     keypad columns, active-low, asynchronous
//   row_n     keypad rows, active-low, one-hot-low while scanning
//   keycode   {1'b0,row,col}; 5'h10 means no key
//   key_ready high while a debounced key is held
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] keycode;
    logic       key_ready;

    modport master (input col_n, output row_n, output keycode, output key_ready);
    modport slave  (output col_n, input row_n, input keycode, input key_ready);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates rows, samples columns, debounces press/release.
// Latency: key_ready rises 1 clk after the DEBOUNCE_TICKS-th matching scan tick; falls likewise on release.
// Backpressure: none; keycode holds through the key_ready falling edge and clears on the next tick.
//
// Ports: clk, rst (async, active-high); kp (keypad_scan_if.master): col_n in, row_n/keycode/key_ready out.
// Optional macro KEYPAD_REPEAT_EN: auto-repeat drops key_ready for one tick every REPEAT_TICKS held ticks.
module keypad_scan #(
    parameter int CLK_DIV        = 25000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_REL} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    keycode_q, keycode_d;
    logic          key_ready_q, key_ready_d;
    logic [3:0]    col_s1_q, col_s2_q;

    logic          tick;
    logic          hit;
    logic [1:0]    hit_col;
    logic          same_hit;
    logic [CW-1:0] cnt_inc;
    logic          cnt_done;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_q + RW'(1);
`else
    // The repeat interval has no effect when auto-repeat is not built.
    logic unused_repeat_ticks;
    assign unused_repeat_ticks = (REPEAT_TICKS != 0);
`endif

    // Free-running scan divider; FSM activity never restarts it.
    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);

    // Exactly one low column is a hit; none or several (ghosting) is not.
    always_comb begin
        hit     = 1'b0;
        hit_col = 2'd0;
        case (~col_s2_q)
            4'b0001: begin hit = 1'b1; hit_col = 2'd0; end
            4'b0010: begin hit = 1'b1; hit_col = 2'd1; end
            4'b0100: begin hit = 1'b1; hit_col = 2'd2; end
            4'b1000: begin hit = 1'b1; hit_col = 2'd3; end
            default: begin hit = 1'b0; hit_col = 2'd0; end
        endcase
    end

    assign same_hit = hit && ({row_q, hit_col} == cand_q);
    assign cnt_inc  = cnt_q + CW'(1);
    assign cnt_done = (cnt_inc == CW'(DEBOUNCE_TICKS));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        keycode_d   = keycode_q;
        key_ready_d = key_ready_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    // Clears the code one tick after a release, never on the release edge itself.
                    keycode_d = 5'h10;
                    if (hit) begin
                        cand_d = {row_q, hit_col};
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d     = HELD;
                            keycode_d   = {1'b0, row_q, hit_col};
                            key_ready_d = 1'b1;
                            cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            state_d = DB_PRESS;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                DB_PRESS: begin
                    if (same_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d     = HELD;
                            keycode_d   = {1'b0, cand_q};
                            key_ready_d = 1'b1;
                            cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                    end
                end
                HELD: begin
                    // The row stays frozen, so keys on other rows cannot be seen here.
                    if (!same_hit) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d     = SCAN;
                            key_ready_d = 1'b0;
                            cnt_d       = '0;
                        end else begin
                            state_d = DB_REL;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // A one-tick low pulse per interval gives the consumer an extra falling edge.
                        if (rep_inc == RW'(REPEAT_TICKS)) begin
                            key_ready_d = 1'b0;
                            rep_d       = '0;
                        end else begin
                            key_ready_d = 1'b1;
                            rep_d       = rep_inc;
                        end
`endif
                    end
                end
                DB_REL: begin
                    if (same_hit) begin
                        state_d     = HELD;
                        key_ready_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d     = SCAN;
                            key_ready_d = 1'b0;
                            cnt_d       = '0;
                        end
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            div_q       <= '0;
            row_q       <= 2'd0;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            keycode_q   <= 5'h10;
            key_ready_q <= 1'b0;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            keycode_q   <= keycode_d;
            key_ready_q <= key_ready_d;
            col_s1_q    <= kp.col_n;
            col_s2_q    <= col_s1_q;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign kp.row_n     = ~(4'b0001 << row_q);
    assign kp.keycode   = keycode_q;
    assign kp.key_ready = key_ready_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad matrix on the row/column pins.
// Latency: expectations are placed on scan-tick edges derived from a bench-side divider.
// Backpressure: not applicable; key_ready falling edges are counted as keystrokes.
module tb_keypad_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scan_if kp_if ();

    logic [15:0] keys = 16'h0000;
    logic [3:0]  col_drv;
    int          checks = 0;
    int          errors = 0;
    int          falls  = 0;
    int          tb_div = 0;
    int          base;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_FALLS = 4;
`else
    localparam int EXP_FALLS = 1;
`endif

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !kp_if.row_n[r]) col_drv[c] = 1'b0;
    end
    assign kp_if.col_n = col_drv;

    keypad_scan #(.CLK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    // Bench copy of the scan divider: value 3 means the next posedge is a tick edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_div <= 0;
        else     tb_div <= (tb_div == 3) ? 0 : tb_div + 1;
    end

    always @(negedge kp_if.key_ready) begin
        if (!rst) falls++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        do @(negedge clk); while (tb_div != 3);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic lvl, input int max_ticks, input string tag);
        int n = 0;
        while (kp_if.key_ready !== lvl && n < max_ticks) begin
            next_tick();
            n++;
        end
        check(tag, {7'd0, kp_if.key_ready}, {7'd0, lvl});
    endtask

    initial begin
        // 1. reset and idle rotation
        #12 rst = 1'b0;
        #1;
        check("rst_row", {4'd0, kp_if.row_n}, 8'h0E);
        check("rst_code", {3'd0, kp_if.keycode}, 8'h10);
        check("rst_rdy", {7'd0, kp_if.key_ready}, 8'h00);
        next_tick();
        check("rot1", {4'd0, kp_if.row_n}, 8'h0D);
        repeat (3) @(posedge clk);
        #1;
        check("dwell", {4'd0, kp_if.row_n}, 8'h0D);
        next_tick();
        check("rot2", {4'd0, kp_if.row_n}, 8'h0B);
        next_tick();
        check("rot3", {4'd0, kp_if.row_n}, 8'h07);
        next_tick();
        check("rot0", {4'd0, kp_if.row_n}, 8'h0E);
        check("idle_rdy", {7'd0, kp_if.key_ready}, 8'h00);

        // 2. row2/col1 press and release
        keys = 16'h0200;
        repeat (4) next_tick();
        check("p_frozen", {4'd0, kp_if.row_n}, 8'h0B);
        check("p_early", {7'd0, kp_if.key_ready}, 8'h00);
        next_tick();
        check("p_rdy", {7'd0, kp_if.key_ready}, 8'h01);
        check("p_code", {3'd0, kp_if.keycode}, 8'h09);
        keys = 16'h0000;
        repeat (2) next_tick();
        check("r_early", {7'd0, kp_if.key_ready}, 8'h01);
        next_tick();
        check("r_fall", {7'd0, kp_if.key_ready}, 8'h00);
        check("r_code", {3'd0, kp_if.keycode}, 8'h09);
        check("r_row", {4'd0, kp_if.row_n}, 8'h0B);
        check("r_falls", falls[7:0], 8'd1);
        @(posedge clk);
        #1;
        check("r_code_hold", {3'd0, kp_if.keycode}, 8'h09);
        next_tick();
        check("r_code_clr", {3'd0, kp_if.keycode}, 8'h10);
        check("r_resume", {4'd0, kp_if.row_n}, 8'h07);

        // 3. row0/col3 bouncing: 2 ticks on, 1 off, then stable
        next_tick();
        check("b_row0", {4'd0, kp_if.row_n}, 8'h0E);
        keys = 16'h0008;
        repeat (2) next_tick();
        check("b_on", {7'd0, kp_if.key_ready}, 8'h00);
        keys = 16'h0000;
        next_tick();
        check("b_off_row", {4'd0, kp_if.row_n}, 8'h0D);
        check("b_off_rdy", {7'd0, kp_if.key_ready}, 8'h00);
        keys = 16'h0008;
        repeat (5) next_tick();
        check("b_wait", {7'd0, kp_if.key_ready}, 8'h00);
        next_tick();
        check("b_rdy", {7'd0, kp_if.key_ready}, 8'h01);
        check("b_code", {3'd0, kp_if.keycode}, 8'h03);
        keys = 16'h0000;
        wait_ready(1'b0, 4, "b_release");
        check("b_falls", falls[7:0], 8'd2);
        next_tick();
        check("b_clr", {3'd0, kp_if.keycode}, 8'h10);
        check("b_resume", {4'd0, kp_if.row_n}, 8'h0D);

        // 4. ghost on row1 (col0 + col2)
        keys = 16'h0050;
        next_tick();
        check("g_row", {4'd0, kp_if.row_n}, 8'h0B);
        check("g_rdy", {7'd0, kp_if.key_ready}, 8'h00);
        repeat (4) next_tick();
        check("g_row2", {4'd0, kp_if.row_n}, 8'h0B);
        check("g_rdy2", {7'd0, kp_if.key_ready}, 8'h00);
        check("g_code", {3'd0, kp_if.keycode}, 8'h10);
        keys = 16'h0000;

        // 5. reset while held, then re-debounce
        keys = 16'h0001;
        wait_ready(1'b1, 10, "x_accept");
        rst = 1'b1;
        #2;
        check("x_rdy", {7'd0, kp_if.key_ready}, 8'h00);
        check("x_code", {3'd0, kp_if.keycode}, 8'h10);
        check("x_row", {4'd0, kp_if.row_n}, 8'h0E);
        #1 rst = 1'b0;
        repeat (2) next_tick();
        check("x_early", {7'd0, kp_if.key_ready}, 8'h00);
        next_tick();
        check("x_reacc", {7'd0, kp_if.key_ready}, 8'h01);
        check("x_code2", {3'd0, kp_if.keycode}, 8'h00);
        keys = 16'h0000;
        wait_ready(1'b0, 5, "x_release");
        check("x_falls", falls[7:0], 8'd3);

        // 6. long hold of key 0F
        base = falls;
        keys = 16'h8000;
        wait_ready(1'b1, 12, "h_accept");
        check("h_code", {3'd0, kp_if.keycode}, 8'h0F);
        repeat (17) next_tick();
        check("h_rdy_end", {7'd0, kp_if.key_ready}, 8'h01);
        check("h_code_end", {3'd0, kp_if.keycode}, 8'h0F);
        keys = 16'h0000;
        wait_ready(1'b0, 6, "h_release");
        repeat (2) next_tick();
        check("h_falls", 8'(falls - base), 8'(EXP_FALLS));
        check("h_clr", {3'd0, kp_if.keycode}, 8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
